div_32_seq: RTL and testbench

- Multi-cycle sequential divider, one quotient bit per Clock.
- Sits directly upstream of the HI/LO register_32 pair:
  - Quotient feeds LO.D.
  - Remainder feeds HI.D.
  - The one-cycle Done pulse drives both Write inputs.
- Results are registered and held stable between operations, so downstream registers never see intermediate values.

---
 rtl/div_32_seq.sv | 168 ++++++++++++++++
 tb/tb_div_32_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/div_32_seq.sv
// Sequential restoring divider feeding the HI/LO register pair (quotient -> LO, remainder -> HI).
// Latency: WIDTH+2 edges from the Start edge to Done (inclusive), 2 edges for divide-by-zero.
// Backpressure: Start is accepted only in IDLE (Busy=0); a Start while Busy is dropped, never queued.
//
// Ports:
//   Clock, Clear       - clock and synchronous active-high reset (Clear beats everything)
//   Start, Dividend,
//   Divisor            - division request; operands captured on the accepting edge
//   Busy               - high from the accepting edge until the result edge
//   Done               - one-cycle pulse when Quotient/Remainder/DivByZero are updated
//   DivByZero          - set with Done when the captured divisor was zero
//   Quotient,
//   Remainder          - registered results, held until the next result or Clear
//
// Build option: define DIV_SIGNED_EN for two's-complement signed division
// (truncating quotient, remainder takes the dividend's sign). Default is unsigned.
module div_32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] prem;     // partial remainder
  logic [WIDTH-1:0] dvd;      // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs;      // captured divisor (magnitude in the signed build)
  logic             zdiv;     // captured divisor was zero

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic             div_zero_in;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
`endif

  assign div_zero_in = (Divisor == '0);

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = div_zero_in ? FINISH : RUN;
      RUN:     if (cnt == '0) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    Busy = (state != IDLE);
  end

  // ---------------------------------------------------------------- operand conditioning
  always_comb begin
`ifdef DIV_SIGNED_EN
    a_mag = Dividend[WIDTH-1] ? -Dividend : Dividend;
    b_mag = Divisor[WIDTH-1]  ? -Divisor  : Divisor;
`else
    a_mag = Dividend;
    b_mag = Divisor;
`endif
  end

  // ---------------------------------------------------------------- restoring step
  // prem < dvs always holds, so shifted < 2*dvs and the top bit of diff is a
  // clean borrow flag: set exactly when the trial subtraction went negative.
  always_comb begin
    shifted = {prem, dvd[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    ge      = ~diff[WIDTH];
  end

  // ---------------------------------------------------------------- datapath and result registers
  always_ff @(posedge Clock) begin
    if (Clear) begin
      cnt       <= '0;
      prem      <= '0;
      dvd       <= '0;
      dvs       <= '0;
      zdiv      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
`ifdef DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            prem <= '0;
            dvs  <= b_mag;
            zdiv <= div_zero_in;
            cnt  <= div_zero_in ? '0 : CW'(WIDTH - 1);
            // Divide-by-zero returns the raw dividend as remainder, so keep it unmodified.
            dvd  <= div_zero_in ? Dividend : a_mag;
`ifdef DIV_SIGNED_EN
            neg_q <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
            neg_r <= Dividend[WIDTH-1];
`endif
          end
        end
        RUN: begin
          prem <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          dvd  <= {dvd[WIDTH-2:0], ge};
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        FINISH: begin
          Done      <= 1'b1;
          DivByZero <= zdiv;
          if (zdiv) begin
            Quotient  <= '1;
            Remainder <= dvd;
          end else begin
`ifdef DIV_SIGNED_EN
            // Most-negative / -1 yields magnitude 2^(WIDTH-1); negating it wraps
            // back to itself, which is the expected overflow result.
            Quotient  <= neg_q ? -dvd  : dvd;
            Remainder <= neg_r ? -prem : prem;
`else
            Quotient  <= dvd;
            Remainder <= prem;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32_seq.sv
module tb_div_32_seq;

  logic        Clock;
  logic        Clear;
  logic        Start;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic [31:0] Quotient;
  logic [31:0] Remainder;

  int tests;
  int failed;
  int done_seen;

  div_32_seq #(.WIDTH(32)) dut (
    .Clock     (Clock),
    .Clear     (Clear),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .Quotient  (Quotient),
    .Remainder (Remainder)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one division and check latency (edges counted from the Start edge, inclusive),
  // the one-cycle Done pulse and the results. Operand inputs are scrambled after
  // the Start edge to confirm they were captured.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] eq, input logic [31:0] er,
                        input logic ez);
    int n;
    @(negedge Clock);
    Start    = 1'b1;
    Dividend = a;
    Divisor  = b;
    @(posedge Clock);
    #1;
    Start    = 1'b0;
    Dividend = ~a;
    Divisor  = 32'h3;
    if (b != 32'h0) chk({tag, ".busy"}, {31'b0, Busy}, 32'd1);
    n = 1;
    while (!Done && n < 100) begin
      @(posedge Clock);
      #1;
      n++;
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".q"}, Quotient, eq);
    chk({tag, ".r"}, Remainder, er);
    chk({tag, ".dbz"}, {31'b0, DivByZero}, {31'b0, ez});
    chk({tag, ".busy_done"}, {31'b0, Busy}, 32'd0);
    @(posedge Clock);
    #1;
    chk({tag, ".done_pulse"}, {31'b0, Done}, 32'd0);
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    done_seen = 0;
    Clear     = 1'b1;
    Start     = 1'b0;
    Dividend  = 32'h0;
    Divisor   = 32'h0;

    // 1. reset and idle
    repeat (2) @(posedge Clock);
    #1;
    chk("rst.busy", {31'b0, Busy}, 32'd0);
    chk("rst.done", {31'b0, Done}, 32'd0);
    chk("rst.dbz",  {31'b0, DivByZero}, 32'd0);
    chk("rst.q",    Quotient, 32'd0);
    chk("rst.r",    Remainder, 32'd0);
    Clear = 1'b0;
    repeat (3) begin
      @(posedge Clock);
      #1;
      chk("idle.busy_done", {30'b0, Busy, Done}, 32'd0);
      chk("idle.q", Quotient, 32'd0);
    end

    // 2. 100 / 7 = 14 r 2, held for 5 idle cycles
    do_div("d100_7", 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0);
    repeat (5) begin
      @(posedge Clock);
      #1;
      chk("hold.q", Quotient, 32'd14);
      chk("hold.r", Remainder, 32'd2);
    end

    // 3. all-ones / 1 (same bits in both builds: -1 / 1 = -1)
    do_div("dmax_1", 32'hFFFF_FFFF, 32'h1, 34, 32'hFFFF_FFFF, 32'h0, 1'b0);

    // 4. divide by zero, then a normal division clears the flag
    do_div("d5_0", 32'd5, 32'd0, 2, 32'hFFFF_FFFF, 32'd5, 1'b1);
    do_div("d9_3", 32'd9, 32'd3, 34, 32'd3, 32'd0, 1'b0);

    // 6. ignored Start while busy, then Clear mid-run aborts the division
    @(negedge Clock);
    Start    = 1'b1;
    Dividend = 32'd100;
    Divisor  = 32'd7;
    @(posedge Clock);
    #1;
    for (int c = 2; c <= 12; c++) begin
      Start    = (c == 5);
      Dividend = (c == 5) ? 32'd50 : 32'd0;
      Divisor  = (c == 5) ? 32'd5  : 32'd0;
      Clear    = (c == 10);
      @(posedge Clock);
      #1;
      if (Done) done_seen++;
      if (c == 6) begin
        chk("abort.busy_mid", {31'b0, Busy}, 32'd1);
        chk("abort.q_stable", Quotient, 32'd3);
      end
      if (c == 10) begin
        chk("abort.busy_clr", {31'b0, Busy}, 32'd0);
        chk("abort.q_clr", Quotient, 32'd0);
        chk("abort.r_clr", Remainder, 32'd0);
      end
    end
    Start = 1'b0;
    Clear = 1'b0;
    repeat (40) begin
      @(posedge Clock);
      #1;
      if (Done) done_seen++;
    end
    chk("abort.no_done", done_seen, 32'd0);
    do_div("d50_5", 32'd50, 32'd5, 34, 32'd10, 32'd0, 1'b0);

`ifdef DIV_SIGNED_EN
    // 5. signed cases
    do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, 32'd1, 1'b0);
    do_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'd0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
